uart_hex_tx_sched: RTL and testbench

//  Shares one UART transmitter between two 34-bit word sources. Requester A is the wishbone read response; requester B is status/debug.

---
 rtl/uart_hex_pkg.sv | 28 ++
 rtl/uart_hex_rr_arb.sv | 29 ++
 rtl/uart_hex_tx_sched.sv | 170 +++++++++++++++++
 tb/tb_uart_hex_tx_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hex_pkg.sv
// Shared types and helpers for the two-requester UART hex word scheduler.
package uart_hex_pkg;

    localparam int WORD_W    = 34;
    localparam int HEX_CHARS = 9;
    localparam int SHIFT_W   = 36;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

    // Lowercase ASCII for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h57 + {4'h0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/uart_hex_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past whichever requester just finished.
module uart_hex_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic [1:0] owner,
    output logic [1:0] gnt
);

    // 0: A wins a tie, 1: B wins a tie
    logic ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= owner[0];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_reg ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/uart_hex_tx_sched.sv
// Schedules 34-bit words from two requesters onto one UART as lowercase hex text,
// one character per TxStart/TxBusy handshake.
module uart_hex_tx_sched
    import uart_hex_pkg::*;
#(
    parameter bit         SEND_EOL    = 1'b1,
    parameter logic [7:0] EOL_CHAR    = 8'h0A,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb_a,
    input  logic [WORD_W-1:0] i_word_a,
    output logic              o_busy_a,
    input  logic              i_stb_b,
    input  logic [WORD_W-1:0] i_word_b,
    output logic              o_busy_b,
    output logic [1:0]        o_grant,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy
);

    localparam int                 TIMER_W    = $clog2(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   EOL_IDX    = CNT_W'(HEX_CHARS);
    localparam logic [CNT_W-1:0]   LAST_CHAR  = SEND_EOL ? CNT_W'(HEX_CHARS) : CNT_W'(HEX_CHARS - 1);

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   word_a_reg, word_a_next;
    logic [WORD_W-1:0]   word_b_reg, word_b_next;
    logic                busy_a_reg, busy_a_next;
    logic                busy_b_reg, busy_b_next;
    logic [1:0]          grant_reg, grant_next;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic                tx_start_reg, tx_start_next;
    logic [SHIFT_W-1:0]  shift_reg, shift_next;
    logic [CNT_W-1:0]    char_cnt_reg, char_cnt_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic                release_word;
    logic [1:0]          arb_gnt;
    logic [7:0]          cur_char;

    uart_hex_rr_arb u_arb (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .req     ({busy_b_reg, busy_a_reg}),
        .advance (release_word),
        .owner   (grant_reg),
        .gnt     (arb_gnt)
    );

    // The control pair is zero-extended so it is sent as an ordinary nibble first.
    assign cur_char = (char_cnt_reg == EOL_IDX) ? EOL_CHAR
                                                : hex_ascii(shift_reg[SHIFT_W-1 -: 4]);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            word_a_reg   <= '0;
            word_b_reg   <= '0;
            busy_a_reg   <= 1'b0;
            busy_b_reg   <= 1'b0;
            grant_reg    <= 2'b00;
            tx_data_reg  <= 8'h00;
            tx_start_reg <= 1'b0;
            shift_reg    <= '0;
            char_cnt_reg <= '0;
            timer_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            word_a_reg   <= word_a_next;
            word_b_reg   <= word_b_next;
            busy_a_reg   <= busy_a_next;
            busy_b_reg   <= busy_b_next;
            grant_reg    <= grant_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            shift_reg    <= shift_next;
            char_cnt_reg <= char_cnt_next;
            timer_reg    <= timer_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_a_next   = word_a_reg;
        word_b_next   = word_b_reg;
        busy_a_next   = busy_a_reg;
        busy_b_next   = busy_b_reg;
        grant_next    = grant_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        shift_next    = shift_reg;
        char_cnt_next = char_cnt_reg;
        timer_next    = timer_reg;
        release_word  = 1'b0;

        // A full holding register ignores strobes until its word has gone out.
        if (i_stb_a && !busy_a_reg) begin
            word_a_next = i_word_a;
            busy_a_next = 1'b1;
        end
        if (i_stb_b && !busy_b_reg) begin
            word_b_next = i_word_b;
            busy_b_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    grant_next    = arb_gnt;
                    shift_next    = arb_gnt[1] ? {2'b00, word_b_reg} : {2'b00, word_a_reg};
                    char_cnt_next = '0;
                    state_next    = SEND;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    tx_data_next  = cur_char;
                    tx_start_next = 1'b1;
                    timer_next    = '0;
                    state_next    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A UART that never shows busy still counts the char as sent.
                if (i_tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = NEXT;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (char_cnt_reg != LAST_CHAR) begin
                    char_cnt_next = char_cnt_reg + CNT_W'(1);
                    shift_next    = shift_reg << 4;
                    state_next    = SEND;
                end else begin
                    release_word = 1'b1;
                    if (grant_reg[0]) begin
                        busy_a_next = 1'b0;
                    end
                    if (grant_reg[1]) begin
                        busy_b_next = 1'b0;
                    end
                    grant_next = 2'b00;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_busy_a   = busy_a_reg;
    assign o_busy_b   = busy_b_reg;
    assign o_grant    = grant_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;

endmodule

// File: tb/tb_uart_hex_tx_sched.sv
// Self-checking bench for uart_hex_tx_sched: fixed vectors, directed corner cases and
// randomized traffic against a word-level reference model.
`timescale 1ns/1ps
module tb_uart_hex_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb_a = 1'b0, stb_b = 1'b0;
    logic [33:0] word_a = '0, word_b = '0;
    logic        busy_a, busy_b;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;

    logic        stb6 = 1'b0;
    logic [33:0] word6 = '0;
    logic        stb6_b = 1'b0;
    logic [33:0] word6_b = '0;
    logic        busy6_a, busy6_b;
    logic [1:0]  grant6;
    logic [7:0]  data6;
    logic        start6;
    logic        tx_busy6 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_hex_tx_sched #(.SEND_EOL(1'b1), .EOL_CHAR(8'h0A), .ACK_TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_stb_a(stb_a), .i_word_a(word_a), .o_busy_a(busy_a),
        .i_stb_b(stb_b), .i_word_b(word_b), .o_busy_b(busy_b),
        .o_grant(grant), .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy)
    );

    uart_hex_tx_sched #(.SEND_EOL(1'b0), .EOL_CHAR(8'h0A), .ACK_TIMEOUT(4)) dut6 (
        .i_clk(clk), .i_reset(rst_n),
        .i_stb_a(stb6), .i_word_a(word6), .o_busy_a(busy6_a),
        .i_stb_b(stb6_b), .i_word_b(word6_b), .o_busy_b(busy6_b),
        .o_grant(grant6), .o_tx_data(data6), .o_tx_start(start6), .i_tx_busy(tx_busy6)
    );

    // Monitor: every start pulse becomes one observed character.
    logic [7:0] mon_data[$];
    logic [1:0] mon_grant[$];
    int         mon_cyc[$];
    logic [7:0] mon6[$];
    int         consec_err = 0;
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            mon_data.push_back(tx_data);
            mon_grant.push_back(grant);
            mon_cyc.push_back(cyc);
        end
        if (tx_start && prev_start) consec_err++;
        prev_start = tx_start;
        if (start6) mon6.push_back(data6);
    end

    // UART model: busy rises one cycle after the start pulse and stays up busy_len cycles.
    int busy_len = 10;
    int hold = 0;
    bit pend = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy = 1'b0;
            hold = 0;
            pend = 1'b0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) tx_busy = 1'b0;
            end
            if (pend) begin
                pend = 1'b0;
                tx_busy = 1'b1;
                hold = busy_len;
            end
            if (tx_start && busy_len > 0) pend = 1'b1;
        end
    end

    function automatic logic [7:0] ref_hex(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(97 + v - 10);
    endfunction

    // Character i (0..9) of a word as text: control pair, eight data nibbles, newline.
    function automatic logic [7:0] ref_char(input logic [33:0] w, input int i);
        if (i == 0) return ref_hex(int'(w[33:32]));
        if (i == 9) return 8'h0A;
        return ref_hex(int'((w >> (4 * (8 - i))) & 34'hF));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon;
        mon_data.delete();
        mon_grant.delete();
        mon_cyc.delete();
        mon6.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        stb_a = 1'b0;
        stb_b = 1'b0;
        stb6 = 1'b0;
        tick(3);
        clear_mon();
        rst_n = 1'b1;
        tick(2);
    endtask

    // Called at a negedge; the strobe is sampled on the following posedge.
    task automatic strobe(input bit sa, input bit sb, input logic [33:0] wa, input logic [33:0] wb);
        stb_a = sa;
        stb_b = sb;
        word_a = wa;
        word_b = wb;
        @(negedge clk);
        stb_a = 1'b0;
        stb_b = 1'b0;
    endtask

    task automatic wait_mon(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (mon_data.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (mon_data.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got %0d chars expected %0d", name, mon_data.size(), n);
        end
    endtask

    task automatic expect_word(input logic [33:0] w, input logic [1:0] own, input string name);
        logic [9:0] got;
        wait_mon(10, 400, name);
        for (int i = 0; i < 10; i++) begin
            if (mon_data.size() == 0) return;
            got = {mon_grant.pop_front(), mon_data.pop_front()};
            void'(mon_cyc.pop_front());
            check(name, 64'(got), 64'({own, ref_char(w, i)}));
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k;
        k = 0;
        while ((busy_a || busy_b || grant != 2'b00) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'({busy_a, busy_b, grant}), 64'd0);
    endtask

    typedef struct {
        bit          use_b;
        logic [33:0] word;
        logic [79:0] exp;
        int          blen;
    } vec_t;

    vec_t tbl[4];
    int   ref_rr;

    initial begin
        #800000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  own;
        logic [33:0] wa, wb;
        int          t0, kind, k;

        tbl[0] = '{1'b0, 34'h2_deadbeef, 80'h32_64_65_61_64_62_65_65_66_0A, 10};
        tbl[1] = '{1'b1, 34'h1_01234567, 80'h31_30_31_32_33_34_35_36_37_0A, 3};
        tbl[2] = '{1'b0, 34'h3_89abcdef, 80'h33_38_39_61_62_63_64_65_66_0A, 0};
        tbl[3] = '{1'b1, 34'h0_f0f0f0f0, 80'h30_66_30_66_30_66_30_66_30_0A, 1};

        do_reset();
        check("reset_busy_a", 64'(busy_a), 64'd0);
        check("reset_busy_b", 64'(busy_b), 64'd0);
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_tx_data", 64'(tx_data), 64'd0);
        check("reset_tx_start", 64'(tx_start), 64'd0);

        // Fixed vectors, including the deadbeef word with a 10-cycle UART.
        for (int i = 0; i < 4; i++) begin
            busy_len = tbl[i].blen;
            own = tbl[i].use_b ? 2'b10 : 2'b01;
            t0 = cyc;
            strobe(!tbl[i].use_b, tbl[i].use_b, tbl[i].word, tbl[i].word);
            wait_mon(10, 400, "vec_chars");
            if (mon_data.size() >= 10) begin
                check("vec_latency", 64'(mon_cyc[0]), 64'(t0 + 3));
                check("vec_busy_last", 64'({busy_b, busy_a}), 64'(own));
                for (int j = 0; j < 10; j++) begin
                    check("vec_char", 64'({mon_grant[j], mon_data[j]}),
                          64'({own, tbl[i].exp[8 * (9 - j) +: 8]}));
                end
            end
            wait_idle(100, "vec_release");
            clear_mon();
        end

        // Simultaneous strobes: pointer after reset favours A; after A alone, B wins.
        do_reset();
        busy_len = 2;
        strobe(1'b1, 1'b1, 34'h1_11111111, 34'h2_22222222);
        expect_word(34'h1_11111111, 2'b01, "tie_first_a");
        expect_word(34'h2_22222222, 2'b10, "tie_then_b");
        wait_idle(100, "tie_idle1");
        strobe(1'b1, 1'b0, 34'h0_0000aaaa, 34'h0);
        expect_word(34'h0_0000aaaa, 2'b01, "solo_a");
        wait_idle(100, "solo_idle");
        strobe(1'b1, 1'b1, 34'h3_33334444, 34'h0_5555cccc);
        expect_word(34'h0_5555cccc, 2'b10, "tie_first_b");
        expect_word(34'h3_33334444, 2'b01, "tie_then_a");
        wait_idle(100, "tie_idle2");

        // Strobe while busy is dropped.
        strobe(1'b1, 1'b0, 34'h1_cafef00d, 34'h0);
        strobe(1'b1, 1'b0, 34'h2_bad0bad0, 34'h0);
        tick(5);
        strobe(1'b1, 1'b0, 34'h2_bad0bad0, 34'h0);
        expect_word(34'h1_cafef00d, 2'b01, "drop_first");
        wait_idle(100, "drop_idle");
        tick(20);
        check("drop_no_extra", 64'(mon_data.size()), 64'd0);

        // UART never shows busy: every char ends on the ack timeout.
        busy_len = 0;
        strobe(1'b1, 1'b0, 34'h0_13579bdf, 34'h0);
        wait_mon(10, 200, "timeout_chars");
        if (mon_data.size() >= 10) begin
            for (int i = 1; i < 10; i++) begin
                check("timeout_spacing", 64'(mon_cyc[i] - mon_cyc[i - 1]), 64'd6);
            end
        end
        expect_word(34'h0_13579bdf, 2'b01, "timeout_word");
        wait_idle(50, "timeout_idle");

        // Reset in the middle of a word.
        busy_len = 3;
        strobe(1'b1, 1'b0, 34'h3_a5a5a5a5, 34'h0);
        wait_mon(3, 200, "midreset_chars");
        tick(1);
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", 64'({busy_a, busy_b, grant, tx_data, tx_start}), 64'd0);
        tick(2);
        clear_mon();
        rst_n = 1'b1;
        tick(30);
        check("midreset_no_pulse", 64'(mon_data.size()), 64'd0);
        check("midreset_idle", 64'({busy_a, busy_b, grant}), 64'd0);
        strobe(1'b1, 1'b0, 34'h2_0badf00d, 34'h0);
        expect_word(34'h2_0badf00d, 2'b01, "midreset_new");
        wait_idle(100, "midreset_idle2");

        // No-EOL instance: nine '0' characters only.
        @(negedge clk);
        stb6 = 1'b1;
        word6 = 34'h0_00000000;
        @(negedge clk);
        stb6 = 1'b0;
        k = 0;
        while (mon6.size() < 9 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tick(80);
        check("noeol_count", 64'(mon6.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            if (mon6.size() > 0) check("noeol_char", 64'(mon6.pop_front()), 64'h30);
        end
        check("noeol_release", 64'({busy6_a, grant6}), 64'd0);

        // Randomized traffic against the word-level model.
        do_reset();
        ref_rr = 0;
        for (int it = 0; it < 25; it++) begin
            wa = {2'($urandom), 32'($urandom)};
            wb = {2'($urandom), 32'($urandom)};
            busy_len = $urandom_range(0, 4);
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    strobe(1'b1, 1'b0, wa, 34'h0);
                    strobe(1'b1, 1'b0, ~wa, 34'h0);
                    expect_word(wa, 2'b01, "rand_a");
                    ref_rr = 1;
                end
                1: begin
                    strobe(1'b0, 1'b1, 34'h0, wb);
                    strobe(1'b0, 1'b1, 34'h0, ~wb);
                    expect_word(wb, 2'b10, "rand_b");
                    ref_rr = 0;
                end
                2: begin
                    strobe(1'b1, 1'b1, wa, wb);
                    strobe(1'b1, 1'b1, ~wa, ~wb);
                    if (ref_rr == 0) begin
                        expect_word(wa, 2'b01, "rand_tie_a");
                        expect_word(wb, 2'b10, "rand_tie_b");
                        ref_rr = 0;
                    end else begin
                        expect_word(wb, 2'b10, "rand_tie_b");
                        expect_word(wa, 2'b01, "rand_tie_a");
                        ref_rr = 1;
                    end
                end
                3: begin
                    k = $urandom_range(2, 20);
                    strobe(1'b1, 1'b0, wa, 34'h0);
                    strobe(1'b1, 1'b0, ~wa, 34'h0);
                    tick(k - 2);
                    strobe(1'b0, 1'b1, 34'h0, wb);
                    expect_word(wa, 2'b01, "rand_stag_a");
                    expect_word(wb, 2'b10, "rand_stag_b");
                    ref_rr = 0;
                end
                default: begin
                    k = $urandom_range(2, 20);
                    strobe(1'b0, 1'b1, 34'h0, wb);
                    strobe(1'b0, 1'b1, 34'h0, ~wb);
                    tick(k - 2);
                    strobe(1'b1, 1'b0, wa, 34'h0);
                    expect_word(wb, 2'b10, "rand_stag_b");
                    expect_word(wa, 2'b01, "rand_stag_a");
                    ref_rr = 1;
                end
            endcase
            wait_idle(100, "rand_idle");
            check("rand_no_extra", 64'(mon_data.size()), 64'd0);
        end

        check("start_consecutive", 64'(consec_err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
